// File: rtl/siapipe_pkg.sv
// siapipe_pkg: shared constants and occupancy-width helper for the siapipe delay line.
package siapipe_pkg;
    localparam int W_DEF = 64;
    localparam int DEPTH_DEF = 4;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/siapipe_if.sv
// siapipe_if: control, data and status bundle for siapipe_delay.
interface siapipe_if
    import siapipe_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int CW = occ_w(DEPTH);
    logic          flush;
    logic          en;
    logic          vldIn;
    logic [W-1:0]  dIn;
    logic          vldOut;
    logic [W-1:0]  dOut;
    logic [CW-1:0] occ;
    logic          idle;

    modport master (output flush, en, vldIn, dIn, input vldOut, dOut, occ, idle);
    modport slave (input flush, en, vldIn, dIn, output vldOut, dOut, occ, idle);
endinterface

// File: rtl/siapipe_stage.sv
// siapipe_stage: one valid+data register with stall and flush.
// SIAPIPE_CLR_DATA_EN zeroes the data on reset, flush and bubbles; otherwise data has no reset.
module siapipe_stage #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         en,
    input  logic         vld_i,
    input  logic [W-1:0] d_i,
    output logic         vld_o,
    output logic [W-1:0] d_o
);
    logic         vld_d, vld_q;
    logic [W-1:0] dat_d, dat_q;

    always_comb begin
        vld_d = flush ? 1'b0 : en ? vld_i : vld_q;
`ifdef SIAPIPE_CLR_DATA_EN
        dat_d = flush ? '0 : en ? (vld_i ? d_i : '0) : dat_q;
`else
        dat_d = en ? d_i : dat_q;
`endif
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) vld_q <= 1'b0;
        else vld_q <= vld_d;

`ifdef SIAPIPE_CLR_DATA_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) dat_q <= '0;
        else dat_q <= dat_d;
`else
    always_ff @(posedge clk)
        dat_q <= dat_d;
`endif

    assign vld_o = vld_q;
    assign d_o = dat_q;
endmodule

// File: rtl/siapipe_delay.sv
// siapipe_delay: DEPTH-stage valid/data delay line with stall, flush-on-new-work and occupancy.
// Optional SIAPIPE_CLR_DATA_EN forces dOut to 0 whenever vldOut is 0.
module siapipe_delay
    import siapipe_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input logic      clk,
    input logic      rst,
    siapipe_if.slave p
);
    localparam int CW = occ_w(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("siapipe_delay: DEPTH must be >= 1");
    end

    logic [DEPTH:0] vld;
    logic [W-1:0]   dat [DEPTH+1];
    logic [CW-1:0]  occ_d, occ_q;
    logic           idle_d, idle_q;

    assign vld[0] = p.vldIn;
    assign dat[0] = p.dIn;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        siapipe_stage #(.W(W)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .flush (p.flush),
            .en    (p.en),
            .vld_i (vld[i]),
            .d_i   (dat[i]),
            .vld_o (vld[i+1]),
            .d_o   (dat[i+1])
        );
    end

    // Entry in and entry out can happen on the same edge; both apply together.
    always_comb begin
        occ_d = p.flush ? '0 : p.en ? occ_q + CW'(p.vldIn) - CW'(vld[DEPTH]) : occ_q;
        idle_d = occ_d == '0;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            occ_q <= '0;
            idle_q <= 1'b1;
        end else begin
            occ_q <= occ_d;
            idle_q <= idle_d;
        end

    assign p.vldOut = vld[DEPTH];
    assign p.dOut = dat[DEPTH];
    assign p.occ = occ_q;
    assign p.idle = idle_q;

    assert property (@(posedge clk) disable iff (rst) occ_q <= CW'(DEPTH));
    assert property (@(posedge clk) disable iff (rst)
        !(p.en && !p.flush && !p.vldIn && p.vldOut && occ_q == '0));
endmodule

// File: tb/tb_siapipe_delay.sv
// tb_siapipe_delay: directed table-driven bench for siapipe_delay at W=64, DEPTH=4.
module tb_siapipe_delay;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    siapipe_if #(.W(64), .DEPTH(4)) bus ();

    siapipe_delay #(.W(64), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .p   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        en;
        logic        vin;
        logic [63:0] din;
        logic        vout;
        logic [63:0] dout;
        logic [2:0]  occ;
        logic        idle;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic f, input logic e, input logic v, input logic [63:0] d,
                       input logic vo, input logic [63:0] dq, input logic [2:0] oc, input logic id);
        vec_t r;
        r.flush = f; r.en = e; r.vin = v; r.din = d;
        r.vout = vo; r.dout = dq; r.occ = oc; r.idle = id;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [63:0] ed,
                             input logic [2:0] eo, input logic ei);
        chk({tag, ".vldOut"}, 64'(bus.vldOut), 64'(ev));
`ifdef SIAPIPE_CLR_DATA_EN
        chk({tag, ".dOut"}, bus.dOut, ev ? ed : 64'h0);
`else
        if (ev) chk({tag, ".dOut"}, bus.dOut, ed);
`endif
        chk({tag, ".occ"}, 64'(bus.occ), 64'(eo));
        chk({tag, ".idle"}, 64'(bus.idle), 64'(ei));
    endtask

    task automatic step(input logic f, input logic e, input logic v, input logic [63:0] d);
        bus.flush = f; bus.en = e; bus.vldIn = v; bus.dIn = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.flush = 1'b0; bus.en = 1'b0; bus.vldIn = 1'b0; bus.dIn = '0;
        // stream 0x11,0x22,0x33 then drain
        add(0,1,1,64'h11, 0,64'h00,1,0);
        add(0,1,1,64'h22, 0,64'h00,2,0);
        add(0,1,1,64'h33, 0,64'h00,3,0);
        add(0,1,0,64'h00, 1,64'h11,3,0);
        add(0,1,0,64'h00, 1,64'h22,2,0);
        add(0,1,0,64'h00, 1,64'h33,1,0);
        add(0,1,0,64'h00, 0,64'h00,0,1);
        // fill 4 then flush with a valid input that must be discarded
        add(0,1,1,64'h01, 0,64'h00,1,0);
        add(0,1,1,64'h02, 0,64'h00,2,0);
        add(0,1,1,64'h03, 0,64'h00,3,0);
        add(0,1,1,64'h04, 1,64'h01,4,0);
        add(1,1,1,64'hAA, 0,64'h00,0,1);
        for (int i = 0; i < 4; i++) add(0,1,0,64'h00, 0,64'h00,0,1);
        // fill 2, stall 5 cycles with toggling vldIn, resume
        add(0,1,1,64'h51, 0,64'h00,1,0);
        add(0,1,1,64'h52, 0,64'h00,2,0);
        for (int i = 0; i < 5; i++) add(0,0,(i % 2) == 0,64'hEE, 0,64'h00,2,0);
        add(0,1,0,64'h00, 0,64'h00,2,0);
        add(0,1,0,64'h00, 1,64'h51,2,0);
        add(0,1,0,64'h00, 1,64'h52,1,0);
        add(0,1,0,64'h00, 0,64'h00,0,1);
        // full pipe, stall with vldOut high, then flush during stall
        add(0,1,1,64'h81, 0,64'h00,1,0);
        add(0,1,1,64'h82, 0,64'h00,2,0);
        add(0,1,1,64'h83, 0,64'h00,3,0);
        add(0,1,1,64'h84, 1,64'h81,4,0);
        add(0,0,1,64'hFF, 1,64'h81,4,0);
        add(0,0,0,64'h00, 1,64'h81,4,0);
        add(1,0,1,64'hFF, 0,64'h00,0,1);
        add(0,1,0,64'h00, 0,64'h00,0,1);
        // bubble pattern 1,0,1
        add(0,1,1,64'h61, 0,64'h00,1,0);
        add(0,1,0,64'h77, 0,64'h00,1,0);
        add(0,1,1,64'h63, 0,64'h00,2,0);
        add(0,1,0,64'h00, 1,64'h61,2,0);
        add(0,1,0,64'h00, 0,64'h00,1,0);
        add(0,1,0,64'h00, 1,64'h63,1,0);
        add(0,1,0,64'h00, 0,64'h00,0,1);

        @(posedge clk);
        @(posedge clk);
        #1;
        check_out("reset", 0, 64'h0, 0, 1);
        #2 rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].flush, tbl[i].en, tbl[i].vin, tbl[i].din);
            check_out($sformatf("row%0d", i), tbl[i].vout, tbl[i].dout, tbl[i].occ, tbl[i].idle);
        end

        // continuous stream: occ settles at 4 with simultaneous in/out
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1, 64'h100 + 64'(i));
            check_out($sformatf("cont%0d", i), i >= 3, 64'h100 + 64'(i) - 64'd3,
                      (i < 3) ? 3'(i + 1) : 3'd4, 1'b0);
        end
        for (int j = 0; j < 4; j++) begin
            step(0, 1, 0, 64'h0);
            check_out($sformatf("drain%0d", j), j < 3, 64'h111 + 64'(j), 3'(3 - j), j == 3);
        end

        // asynchronous reset mid-stream, off the clock edge
        for (int i = 0; i < 4; i++) step(0, 1, 1, 64'h90 + 64'(i));
        check_out("prerst", 1, 64'h90, 4, 0);
        #2 rst = 1'b1;
        #1 check_out("asyncrst", 0, 64'h0, 0, 1);
        #2 rst = 1'b0;
        step(0, 1, 0, 64'h0);
        check_out("postrst", 0, 64'h0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
